mips_fetch_unit: RTL and testbench

MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

---
 rtl/mips_fetch_unit_if.sv | 47 ++++
 rtl/mips_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_mips_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel,
// redirect input from execute, and the instruction stream towards decode.
// "master" is the fetch unit's view, "slave" is the surrounding environment.
interface mips_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instr,
        output instr_pc,
        output instr_pc_plus4,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        input  instr_pc_plus4,
        output instr_ready
    );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch unit with a credit-limited prefetch queue.
// Requests are issued while (in-flight + queued) < DEPTH, responses return in
// order and are tagged with the PC of the request they answer, and a redirect
// flushes the queue and arranges for still-outstanding responses to be dropped.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,  // bits [1:0] must be zero
    parameter int          DEPTH    = 4               // power of two, >= 2
) (
    input  logic              clk,
    input  logic              reset,   // synchronous, active low
    mips_fetch_unit_if.master bus
);

    localparam int PW = $clog2(DEPTH);  // FIFO pointer width
    localparam int CW = PW + 1;         // counter width, holds 0..DEPTH

    // BOOT lasts one cycle after reset and issues nothing; RUN is permanent.
    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]    state_q,        state_d;
    logic [31:0]   fetch_pc_q,     fetch_pc_d;
    logic [31:0]   next_resp_pc_q, next_resp_pc_d;
    logic [CW-1:0] inflight_q,     inflight_d;
    logic [CW-1:0] discard_q,      discard_d;
    logic [CW-1:0] count_q,        count_d;
    logic [PW-1:0] rd_ptr_q,       rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,       wr_ptr_d;

    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_word_q [DEPTH];

    // ------------------------------------------------------------------
    // Handshake and status terms
    // ------------------------------------------------------------------
    logic          redirect;
    logic [31:0]   redirect_target;
    logic [CW:0]   credit_used;
    logic          req_valid;
    logic          accept;
    logic          resp;
    logic          fifo_empty;
    logic          head_valid;
    logic          consume;
    logic          push_en;
    logic [31:0]   head_pc;
    logic [31:0]   head_word;

    assign redirect        = bus.redirect_valid;
    assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
    assign resp            = bus.imem_resp_valid;

    // Outstanding requests plus queued words must never exceed the queue size,
    // so every in-flight response is guaranteed a slot when it lands.
    assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
    assign req_valid   = (state_q == ST_RUN) && !redirect
                         && (credit_used < (CW + 1)'(DEPTH));
    assign accept      = req_valid && bus.imem_req_ready;

    assign fifo_empty  = (count_q == '0);
    assign head_valid  = !fifo_empty && !redirect;
    assign consume     = head_valid && bus.instr_ready;

    assign head_pc     = fifo_pc_q[rd_ptr_q];
    assign head_word   = fifo_word_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Outputs: driven only from registers and the FIFO head. The head is
    // masked to zero while empty so reset leaves instr/instr_pc at 0.
    // ------------------------------------------------------------------
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.instr_valid    = head_valid;
    assign bus.instr          = fifo_empty ? 32'h0 : head_word;
    assign bus.instr_pc       = fifo_empty ? 32'h0 : head_pc;
    assign bus.instr_pc_plus4 = bus.instr_pc + 32'd4;

    // Next-state logic: redirect outranks issue, push and pop.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        state_d        = ST_RUN;
        fetch_pc_d     = fetch_pc_q;
        next_resp_pc_d = next_resp_pc_q;
        inflight_d     = inflight_q + CW'(accept) - CW'(resp);
        discard_d      = discard_q;
        count_d        = count_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        push_en        = 1'b0;

        if (redirect) begin
            // No issue happens this cycle (req_valid is low), so inflight_d is
            // exactly the number of old-stream responses still to come back.
            fetch_pc_d     = redirect_target;
            next_resp_pc_d = redirect_target;
            discard_d      = inflight_d;
            count_d        = '0;
            rd_ptr_d       = '0;
            wr_ptr_d       = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end

            if (resp) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    // Only kept responses advance the tracker: dropped ones
                    // belong to the stream that preceded the last redirect.
                    push_en        = 1'b1;
                    next_resp_pc_d = next_resp_pc_q + 32'd4;
                    wr_ptr_d       = wr_ptr_q + PW'(1);
                end
            end

            if (consume) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end

            count_d = count_q + CW'(push_en) - CW'(consume);
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state_q        <= ST_BOOT;
            fetch_pc_q     <= RESET_PC;
            next_resp_pc_q <= RESET_PC;
            inflight_q     <= '0;
            discard_q      <= '0;
            count_q        <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            next_resp_pc_q <= next_resp_pc_d;
            inflight_q     <= inflight_d;
            discard_q      <= discard_d;
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
        end
    end

    // Queue storage: write the tagged response word into the tail slot.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; count_q alone
        // decides validity, and leaving it unreset lets it map to plain RAM.
        if (push_en) begin
            fifo_pc_q[wr_ptr_q]   <= next_resp_pc_q;
            fifo_word_q[wr_ptr_q] <= bus.imem_resp_data;
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: stimulus pushes expected {pc, word,
// pc+4} entries, an independent monitor pops and compares every consumed
// instruction, and a behavioural memory returns word = addr ^ 0xA5A55A5A.
module tb_mips_fetch_unit;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mips_fetch_unit_if bus ();

    mips_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [31:0] pc4;
    } exp_t;
    exp_t exp_q[$];

    task automatic expect_instr(input logic [31:0] pc, input logic [31:0] pc4);
        exp_q.push_back('{pc, mem_word(pc), pc4});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_instr: got pc 0x%08h required none", bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", bus.instr_pc, e.pc);
                    check("instr_word", bus.instr, e.word);
                    check("instr_pc_plus4", bus.instr_pc_plus4, e.pc4);
                end
            end
        end
    end

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t       pend_q[$];
    logic [31:0] req_log[$];
    int          budget    = 0;
    bit          mem_stall = 1'b0;
    int          cyc       = 0;

    initial begin : memory
        pend_t p;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            if (!mem_stall && pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem_word(p.addr);
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = 32'h0;
            end
            bus.imem_req_ready = (budget > 0);
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                req_log.push_back(bus.imem_req_addr);
                pend_q.push_back('{bus.imem_req_addr, cyc + 1});
                budget--;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_log(input int n, input int limit, input string name);
        int k = 0;
        while (req_log.size() < n && k < limit) begin
            @(negedge clk);
            #4;
            k++;
        end
        if (req_log.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got %0d requests required %0d", name, req_log.size(), n);
        end
    endtask

    task automatic wait_drain(input int limit, input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk);
            #4;
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_drain_timeout: got %0d pending required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 32'hDEAD_DEAD;
    endfunction

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int k;
        int base;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #4;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        check("rst_instr_pc_plus4", bus.instr_pc_plus4, 32'h4);

        // Basic stream: 1-cycle memory, decode always ready
        @(negedge clk);
        reset = 1'b1;
        budget = 3;
        bus.instr_ready = 1'b1;
        expect_instr(32'h0, 32'h4);
        expect_instr(32'h4, 32'h8);
        expect_instr(32'h8, 32'hC);
        #4;
        check("boot_no_req", 32'(bus.imem_req_valid), 32'h0);
        k = 0;
        while (!bus.instr_valid && k < 10) begin
            @(negedge clk);
            #4;
            k++;
        end
        check("first_valid_latency", 32'(k), 32'd3);
        wait_drain(40, "basic");
        check("basic_req0", log_at(0), 32'h0);
        check("basic_req1", log_at(1), 32'h4);
        check("basic_req2", log_at(2), 32'h8);

        // Backpressure from a fresh reset
        @(negedge clk);
        reset = 1'b0;
        bus.instr_ready = 1'b0;
        budget = 0;
        @(negedge clk);
        reset = 1'b1;
        req_log.delete();
        budget = 6;
        repeat (12) @(negedge clk);
        #4;
        check("bp_accepted", 32'(req_log.size()), 32'd4);
        check("bp_req_valid_low", 32'(bus.imem_req_valid), 32'h0);
        check("bp_req3", log_at(3), 32'hC);
        @(negedge clk);
        expect_instr(32'h0,  32'h4);
        expect_instr(32'h4,  32'h8);
        expect_instr(32'h8,  32'hC);
        expect_instr(32'hC,  32'h10);
        expect_instr(32'h10, 32'h14);
        expect_instr(32'h14, 32'h18);
        bus.instr_ready = 1'b1;
        wait_drain(60, "bp");
        check("bp_resume_req", log_at(4), 32'h10);

        // Redirect with two requests in flight
        @(negedge clk);
        mem_stall = 1'b1;
        budget = 2;
        wait_log(8, 20, "redir_issue");
        check("redir_old_req", log_at(7), 32'h1C);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #4;
        check("redir_req_suppressed", 32'(bus.imem_req_valid), 32'h0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        mem_stall = 1'b0;
        budget = 2;
        expect_instr(32'h40, 32'h44);
        expect_instr(32'h44, 32'h48);
        wait_drain(40, "redir");
        check("redir_first_req", log_at(8), 32'h40);

        // Redirect coinciding with a response and a consume
        @(negedge clk);
        bus.instr_ready = 1'b0;
        budget = 1;
        k = 0;
        while (!bus.instr_valid && k < 10) begin
            @(negedge clk);
            #4;
            k++;
        end
        check("simul_head_pc", bus.instr_pc, 32'h48);
        @(negedge clk);
        mem_stall = 1'b1;
        budget = 1;
        base = req_log.size();
        wait_log(base + 1, 10, "simul_issue");
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        bus.instr_ready    = 1'b1;
        mem_stall = 1'b0;
        #4;
        check("simul_resp_present", 32'(bus.imem_resp_valid), 32'h1);
        check("simul_instr_forced_low", 32'(bus.instr_valid), 32'h0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        budget = 1;
        base = req_log.size();
        expect_instr(32'h80, 32'h84);
        #4;
        check("simul_fifo_empty", 32'(bus.instr_valid), 32'h0);
        wait_drain(20, "simul");
        check("simul_next_req", log_at(base), 32'h80);

        // Address wrap and misaligned redirect target
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        budget = 2;
        base = req_log.size();
        expect_instr(32'hFFFF_FFFC, 32'h0);
        expect_instr(32'h0000_0000, 32'h4);
        wait_drain(20, "wrap");
        check("wrap_req0", log_at(base), 32'hFFFF_FFFC);
        check("wrap_req1", log_at(base + 1), 32'h0);

        // Reset mid-stream with three queued entries
        @(negedge clk);
        bus.instr_ready = 1'b0;
        budget = 3;
        base = req_log.size();
        wait_log(base + 3, 20, "mid_fill");
        repeat (4) @(negedge clk);
        #4;
        check("mid_head_valid", 32'(bus.instr_valid), 32'h1);
        check("mid_head_pc", bus.instr_pc, 32'h4);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        budget = 1;
        base = req_log.size();
        expect_instr(32'h0, 32'h4);
        #4;
        check("mid_instr_valid", 32'(bus.instr_valid), 32'h0);
        check("mid_req_valid", 32'(bus.imem_req_valid), 32'h0);
        @(negedge clk);
        bus.instr_ready = 1'b1;
        wait_drain(20, "mid");
        check("mid_first_req", log_at(base), 32'h0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
